led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Pattern sequencer and brightness controller for the board status LEDs. A prescaler derives a slow step tick from `clk`, and a four-mode pattern engine (Gray count, bounce scan, fill bar, blink) advances on each tick. A PWM stage dims the result. Mode changes arrive through a req/ack handshake and are applied only on a tick boundary, so a pattern is never cut mid-step. The block sits between top-level control logic and the LED pins and replaces free-running LED counters in the top levels.

## Interface

- `NUM_LEDS`, 5: number of LED outputs, ≥2.
- `LOG2DELAY`, 22: step tick period is 2^LOG2DELAY cycles, ≥1.
- `PWM_BITS`, 4: brightness and PWM counter width.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mode_req`  in  1  mode change request; held high until `mode_ack`.
- `mode_sel`  in  2  requested mode (0 GRAY, 1 SCAN, 2 FILL, 3 BLINK); stable while `mode_req` is high.
- `mode_ack`  out  1  one-cycle pulse: the requested mode is now active.
- `pause`  in  1  freezes prescaler and pattern; PWM keeps running.
- `bright_we`  in  1  write strobe for brightness.
- `bright_in`  in  PWM_BITS  brightness value; all-ones means fully on.
- `cur_mode`  out  2  active mode.
- `leds`  out  NUM_LEDS  registered LED drive; bit 0 is LED1.

## Operation

- Reset state: prescaler 0, PWM counter 0, mode GRAY, step state 0, pattern 0, brightness all-ones, FSM RUN. Outputs `leds` = 0, `mode_ack` = 0, `cur_mode` = 0.
- Prescaler (LOG2DELAY bits):
  - Increments each cycle while `pause` = 0 and holds while `pause` = 1.
  - `tick` is high in the cycle where the prescaler equals all-ones and `pause` = 0; the prescaler then wraps to 0.
- Pattern engine. On each `tick`, and only then, the step state advances and the pattern register loads the next value:
  - GRAY: step s (NUM_LEDS bits, wraps at all-ones to 0); pattern = s ^ (s>>1).
  - SCAN: one-hot position p and direction d. p runs 0 up to NUM_LEDS-1, then back down to 0, with no repeat at either end. d flips when p reaches an end.
  - FILL: k runs 0..NUM_LEDS, then wraps to 0; pattern = (1<<k)-1.
  - BLINK: pattern toggles between all-ones and all-zeros.
- Step-0 patterns: GRAY 0, SCAN bit 0 set (d = up), FILL 0, BLINK all-ones.
- Mode FSM, with states RUN and PEND:
  - RUN: if `mode_req` = 1 and `mode_ack` = 0 this cycle, latch `mode_sel` into the pending register and go to PEND.
  - PEND: `mode_req` and `mode_sel` are ignored. On `tick`: mode ← pending, step state ← step 0 of the new mode, pattern ← that step-0 pattern (no normal advance that tick), go to RUN, and `mode_ack` is registered high for the next cycle.
  - A request for the already-active mode follows the same path: it waits for a tick, restarts at step 0, and acks.
- PWM:
  - Counter (PWM_BITS) free-runs every cycle and ignores `pause`.
  - on = (brightness == all-ones) | (pwm_cnt < brightness).
  - Brightness 0 gives LEDs always off.
  - `bright_we` loads `bright_in` at the next edge. This is accepted in any FSM state and does not touch mode or step.
- Output: `leds` ← pattern & {NUM_LEDS{on}}, registered.
- `rst` overrides every other input. Reset during PEND drops the pending request and no ack is issued.

## Timing

- First tick after reset release: cycle 2^LOG2DELAY-1, counting the first post-reset cycle as 0.
- The pattern register updates at the edge ending the tick cycle. `leds` shows the new pattern one cycle later, gated by PWM.
- Mode change latency: request seen in RUN (1 cycle to reach PEND), then wait for the next tick, then `mode_ack` and the new `cur_mode` appear together in the cycle after the tick. The new pattern reaches `leds` one cycle after that.
- A request raised in the same cycle as a tick while in RUN reaches PEND then and is applied at the following tick.
- `pause` high in PEND defers the switch; `mode_ack` never fires while paused.
- `mode_req` still high in the `mode_ack` cycle is ignored. A requester holding it high afterwards starts a new transaction.

## Test plan

Parameters for all scenarios: LOG2DELAY=2, NUM_LEDS=5, PWM_BITS=4.

- Reset, GRAY mode, brightness 15 → `leds` = 00000 until the first tick, then 00001, 00011, 00010, 00110 on successive ticks. After 32 ticks the sequence returns to 00000.
- Request SCAN → `mode_ack` is a single pulse the cycle after the next tick and `cur_mode` = 1. `leds` then shows 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010.
- Request FILL, then BLINK → FILL shows 00000, 00001, 00011, 00111, 01111, 11111, 00000. BLINK shows 11111, 00000, 11111.
- Brightness 4 in BLINK on-phase → `leds` = 11111 for 4 of every 16 cycles and 00000 for the other 12. Brightness 0 → always 00000.
- `pause` high for 20 cycles during PEND → no tick, pattern held, no `mode_ack`. After release, the ack fires the cycle after the next tick, within 4 cycles.
- `rst` pulse during PEND → all outputs return to reset values and no ack follows. `rst` asserted in the same cycle as `mode_req` and a tick → reset wins.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Status-LED pattern sequencer: slow step tick, four pattern modes with a
// tick-aligned mode-change handshake, and PWM dimming on the registered output.
module led_seq_ctrl #(
  parameter int NUM_LEDS  = 5,
  parameter int LOG2DELAY = 22,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_req,
  input  logic [1:0]          mode_sel,
  output logic                mode_ack,
  input  logic                pause,
  input  logic                bright_we,
  input  logic [PWM_BITS-1:0] bright_in,
  output logic [1:0]          cur_mode,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int SW = NUM_LEDS;
  localparam logic [SW-1:0] STEP_LAST = SW'(NUM_LEDS - 1);
  localparam logic [SW-1:0] STEP_FULL = SW'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic {ST_RUN, ST_PEND} state_t;
  typedef enum logic [1:0] {M_GRAY, M_SCAN, M_FILL, M_BLINK} mode_t;

  state_t                state_q;
  mode_t                 mode_q;
  mode_t                 pend_q;
  logic [LOG2DELAY-1:0]  presc_q;
  logic [PWM_BITS-1:0]   pwm_q;
  logic [PWM_BITS-1:0]   bright_q;
  logic [SW-1:0]         step_q;
  logic [SW-1:0]         step_d;
  logic                  dir_down_q;
  logic                  dir_down_d;
  logic [NUM_LEDS-1:0]   pat_q;
  logic [NUM_LEDS-1:0]   pat_d;
  logic [NUM_LEDS-1:0]   init_pat;
  logic [NUM_LEDS-1:0]   scan_mask;
  logic [NUM_LEDS-1:0]   fill_mask;
  logic                  ack_q;
  logic [NUM_LEDS-1:0]   leds_q;
  logic                  tick;
  logic                  pwm_on;

  assign tick   = ~pause & (&presc_q);
  assign pwm_on = (&bright_q) | (pwm_q < bright_q);

  // Normal one-step advance of the active mode; only committed on a tick in RUN.
  always_comb begin
    step_d     = step_q;
    dir_down_d = dir_down_q;
    case (mode_q)
      M_GRAY: step_d = step_q + SW'(1);
      M_SCAN: begin
        step_d = dir_down_q ? (step_q - SW'(1)) : (step_q + SW'(1));
        if (step_d == STEP_LAST) begin
          dir_down_d = 1'b1;
        end else if (step_d == '0) begin
          dir_down_d = 1'b0;
        end
      end
      M_FILL:  step_d = (step_q == STEP_FULL) ? '0 : (step_q + SW'(1));
      default: step_d = step_q ^ SW'(1);
    endcase
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_mask
    assign scan_mask[gi] = (step_d == SW'(gi));
    assign fill_mask[gi] = (SW'(gi) < step_d);
  end

  always_comb begin
    pat_d = '0;
    case (mode_q)
      M_GRAY:  pat_d = step_d ^ (step_d >> 1);
      M_SCAN:  pat_d = scan_mask;
      M_FILL:  pat_d = fill_mask;
      default: pat_d = step_d[0] ? '0 : '1;
    endcase
  end

  always_comb begin
    init_pat = '0;
    case (pend_q)
      M_SCAN:  init_pat = LED_ONE;
      M_BLINK: init_pat = '1;
      default: init_pat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      mode_q     <= M_GRAY;
      pend_q     <= M_GRAY;
      presc_q    <= '0;
      pwm_q      <= '0;
      bright_q   <= '1;
      step_q     <= '0;
      dir_down_q <= 1'b0;
      pat_q      <= '0;
      ack_q      <= 1'b0;
      leds_q     <= '0;
    end else begin
      if (!pause) begin
        presc_q <= presc_q + LOG2DELAY'(1);
      end
      pwm_q <= pwm_q + PWM_BITS'(1);
      if (bright_we) begin
        bright_q <= bright_in;
      end
      ack_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            step_q     <= step_d;
            dir_down_q <= dir_down_d;
            pat_q      <= pat_d;
          end
          // The ack cycle itself never opens a new transaction.
          if (mode_req && !ack_q) begin
            pend_q  <= mode_t'(mode_sel);
            state_q <= ST_PEND;
          end
        end
        default: begin
          if (tick) begin
            mode_q     <= pend_q;
            step_q     <= '0;
            dir_down_q <= 1'b0;
            pat_q      <= init_pat;
            state_q    <= ST_RUN;
            ack_q      <= 1'b1;
          end
        end
      endcase
      leds_q <= pat_q & {NUM_LEDS{pwm_on}};
    end
  end

  assign mode_ack = ack_q;
  assign cur_mode = mode_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected LED/mode samples
// and acks by absolute cycle; a negedge monitor pops and compares them.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;
  logic       pause;
  logic       bright_we;
  logic [3:0] bright_in;
  logic [1:0] cur_mode;
  logic [4:0] leds;

  led_seq_ctrl #(
    .NUM_LEDS (5),
    .LOG2DELAY(2),
    .PWM_BITS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .mode_sel (mode_sel),
    .mode_ack (mode_ack),
    .pause    (pause),
    .bright_we(bright_we),
    .bright_in(bright_in),
    .cur_mode (cur_mode),
    .leds     (leds)
  );

  typedef struct {
    int         cyc;
    logic [4:0] leds;
    logic [1:0] mode;
  } led_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
  } ack_exp_t;

  led_exp_t led_q[$];
  ack_exp_t ack_q[$];
  led_exp_t le;
  ack_exp_t ae;

  int checks = 0;
  int failures = 0;
  int abs_cyc = -2;
  bit done = 0;
  bit final_done = 0;

  logic [4:0] scan_exp [10] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};
  logic [4:0] fill_exp [8]  = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                5'b11111, 5'b00000, 5'b00001};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the initial reset is released.
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  task automatic exp_led(input int c, input logic [4:0] v, input logic [1:0] m);
    led_exp_t e;
    e.cyc  = c;
    e.leds = v;
    e.mode = m;
    led_q.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic [1:0] m);
    ack_exp_t e;
    e.cyc  = c;
    e.mode = m;
    ack_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (abs_cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_req(input logic [1:0] sel);
    mode_req = 1'b1;
    mode_sel = sel;
  endtask

  // Holds the request until the ack is seen; an ack that never comes leaves
  // its expectation in the queue and is reported at the end.
  task automatic finish_req();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (mode_ack) break;
    end
    mode_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mode_ack) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected cyc=%0d got mode_ack=1 cur_mode=%0d required mode_ack=0",
                 abs_cyc, cur_mode);
      end else begin
        ae = ack_q.pop_front();
        if (ae.cyc != abs_cyc || cur_mode !== ae.mode) begin
          failures++;
          $display("FAIL ack cyc=%0d got cur_mode=%0d required cyc=%0d cur_mode=%0d",
                   abs_cyc, cur_mode, ae.cyc, ae.mode);
        end else begin
          $display("ack   cyc=%0d cur_mode=%0d ok", abs_cyc, cur_mode);
        end
      end
    end
    while (led_q.size() > 0 && led_q[0].cyc <= abs_cyc) begin
      le = led_q.pop_front();
      checks++;
      if (le.cyc != abs_cyc || leds !== le.leds || cur_mode !== le.mode) begin
        failures++;
        $display("FAIL leds cyc=%0d got leds=%b mode=%0d required cyc=%0d leds=%b mode=%0d",
                 abs_cyc, leds, cur_mode, le.cyc, le.leds, le.mode);
      end else begin
        $display("leds  cyc=%0d leds=%b mode=%0d ok", abs_cyc, leds, cur_mode);
      end
    end
    if (done && !final_done) begin
      final_done = 1;
      checks++;
      if (ack_q.size() != 0) begin
        failures++;
        $display("FAIL ack_missing got outstanding=%0d required outstanding=0", ack_q.size());
      end
      checks++;
      if (led_q.size() != 0) begin
        failures++;
        $display("FAIL leds_unchecked got outstanding=%0d required outstanding=0", led_q.size());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog got time=%0t required finish before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    mode_req  = 1'b0;
    mode_sel  = 2'd0;
    pause     = 1'b0;
    bright_we = 1'b0;
    bright_in = 4'd0;

    // GRAY from reset: tick n lands in cycle 4n-1, visible on leds in cycle 4n+1.
    exp_led(0,   5'b00000, 2'd0);
    exp_led(4,   5'b00000, 2'd0);
    exp_led(5,   5'b00001, 2'd0);
    exp_led(9,   5'b00011, 2'd0);
    exp_led(13,  5'b00010, 2'd0);
    exp_led(17,  5'b00110, 2'd0);
    exp_led(125, 5'b10000, 2'd0);
    exp_led(129, 5'b00000, 2'd0);
    exp_led(133, 5'b00001, 2'd0);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // SCAN: request in 134, PEND in 135 (tick), ack in 136.
    wait_until(134);
    exp_ack(136, 2'd1);
    exp_led(136, 5'b00001, 2'd1);
    for (int i = 0; i < 10; i++) exp_led(137 + 4 * i, scan_exp[i], 2'd1);
    start_req(2'd1);
    finish_req();

    // FILL: request in 174, tick in 175, ack in 176.
    wait_until(174);
    exp_ack(176, 2'd2);
    exp_led(176, 5'b00010, 2'd2);
    for (int i = 0; i < 8; i++) exp_led(177 + 4 * i, fill_exp[i], 2'd2);
    start_req(2'd2);
    finish_req();

    // BLINK requested in a tick cycle: FILL still advances, switch at tick 207.
    wait_until(203);
    exp_ack(208, 2'd3);
    exp_led(209, 5'b11111, 2'd3);
    exp_led(213, 5'b00000, 2'd3);
    exp_led(217, 5'b11111, 2'd3);
    start_req(2'd3);
    finish_req();

    // Brightness 4, pattern frozen on all-ones by pause.
    wait_until(216);
    for (int c = 224; c <= 239; c++)
      exp_led(c, (c >= 225 && c <= 228) ? 5'b11111 : 5'b00000, 2'd3);
    bright_we = 1'b1;
    bright_in = 4'd4;
    wait_until(217);
    bright_we = 1'b0;
    wait_until(218);
    pause = 1'b1;

    wait_until(240);
    for (int c = 242; c <= 257; c++) exp_led(c, 5'b00000, 2'd3);
    bright_we = 1'b1;
    bright_in = 4'd0;
    wait_until(241);
    bright_we = 1'b0;

    // Request while paused: held in PEND until pause drops at 281.
    wait_until(258);
    bright_we = 1'b1;
    bright_in = 4'd15;
    wait_until(259);
    bright_we = 1'b0;
    wait_until(260);
    exp_ack(283, 2'd1);
    exp_led(265, 5'b11111, 2'd3);
    exp_led(280, 5'b11111, 2'd3);
    exp_led(283, 5'b11111, 2'd1);
    exp_led(284, 5'b00001, 2'd1);
    exp_led(288, 5'b00010, 2'd1);
    start_req(2'd1);
    wait_until(281);
    pause = 1'b0;
    finish_req();

    // Reset during PEND: no ack, mode/brightness/prescaler/PWM all restart.
    wait_until(290);
    exp_led(292, 5'b00100, 2'd1);
    exp_led(293, 5'b00000, 2'd0);
    exp_led(298, 5'b00000, 2'd0);
    for (int c = 299; c <= 302; c++) exp_led(c, 5'b00001, 2'd0);
    start_req(2'd2);
    wait_until(291);
    bright_we = 1'b1;
    bright_in = 4'd4;
    wait_until(292);
    bright_we = 1'b0;
    mode_req  = 1'b0;
    rst       = 1'b1;
    wait_until(294);
    rst = 1'b0;

    // Reset coinciding with a request and a tick.
    wait_until(305);
    exp_led(306, 5'b00000, 2'd0);
    exp_led(310, 5'b00000, 2'd0);
    exp_led(311, 5'b00001, 2'd0);
    rst      = 1'b1;
    mode_req = 1'b1;
    mode_sel = 2'd3;
    wait_until(306);
    rst      = 1'b0;
    mode_req = 1'b0;

    wait_until(330);
    done = 1;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
